// File: rtl/ex_stage_mc_pkg.sv
// Shared opcode/class constants and FSM encoding for the execute stage.
// EX_HILO_EN adds the MOVE class (MFHI/MFLO) used by the top.
package ex_stage_mc_pkg;

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_MUL  = 8'hA9;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MFLO = 8'h12;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;
  localparam logic [2:0] SEL_MUL   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  function automatic logic is_mul_op(input logic [2:0] sel, input logic [7:0] op);
    return (sel == SEL_MUL) && (op == OP_MUL);
  endfunction

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative unsigned shift-add multiplier: bit 0 is folded in at start,
// the remaining DATA_W-1 bits take one cycle each; done pulses when complete.
module ex_mul_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else if (start) begin
      acc    <= b[0] ? PROD_W'(a) : '0;
      mcand  <= PROD_W'(a) << 1;
      mplier <= b >> 1;
      cnt    <= CNT_W'(DATA_W - 1);
      done   <= 1'b0;
    end else if (busy) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      done   <= (cnt == CNT_W'(1));
    end else begin
      done   <= 1'b0;
    end
  end

  assign busy    = (cnt != '0);
  assign product = acc;

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: single-cycle logic/shift/arith unit plus a stalling iterative MUL.
// Define EX_HILO_EN to keep the full product in HI/LO and enable MFHI/MFLO.
module ex_stage_mc
  import ex_stage_mc_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [7:0]        aluop,
  input  logic [2:0]        alusel,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic              we_i,
  output logic              stall_req,
  output logic              out_valid,
  output logic              we_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [DATA_W-1:0] w_data_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  ex_state_e           state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   mul_addr;
  logic                mul_we;
  logic                accept, mul_start, load_single, load_mul;
  logic                mul_busy, mul_done;
  logic [2*DATA_W-1:0] mul_product;
  logic [DATA_W-1:0]   alu_result;
  logic [SHAMT_W-1:0]  shamt;

`ifdef EX_HILO_EN
  logic [DATA_W-1:0] hi, lo;
`endif

  assign shamt = reg1[SHAMT_W-1:0];

  // Single-cycle result; any opcode/class mismatch yields zero
  always_comb begin
    alu_result = '0;
    case (alusel)
      SEL_LOGIC: begin
        case (aluop)
          OP_OR:   alu_result = reg1 | reg2;
          OP_AND:  alu_result = reg1 & reg2;
          OP_XOR:  alu_result = reg1 ^ reg2;
          OP_NOR:  alu_result = ~(reg1 | reg2);
          default: alu_result = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop)
          OP_SLL:  alu_result = reg2 << shamt;
          OP_SRL:  alu_result = reg2 >> shamt;
          OP_SRA:  alu_result = $unsigned($signed(reg2) >>> shamt);
          default: alu_result = '0;
        endcase
      end
      SEL_ARITH: begin
        case (aluop)
          OP_ADDU: alu_result = reg1 + reg2;
          OP_SUBU: alu_result = reg1 - reg2;
          default: alu_result = '0;
        endcase
      end
`ifdef EX_HILO_EN
      SEL_MOVE: begin
        case (aluop)
          OP_MFHI: alu_result = hi;
          OP_MFLO: alu_result = lo;
          default: alu_result = '0;
        endcase
      end
`endif
      default: alu_result = '0;
    endcase
  end

  // Next-state and control; stall_req rises in the accept cycle itself
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    mul_start   = 1'b0;
    load_single = 1'b0;
    load_mul    = 1'b0;
    stall_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = in_valid && !flush && !rst;
        if (accept && is_mul_op(alusel, aluop)) begin
          mul_start  = 1'b1;
          stall_req  = 1'b1;
          state_next = ST_BUSY;
        end else if (accept) begin
          load_single = 1'b1;
        end
      end
      ST_BUSY: begin
        stall_req = 1'b1;
        if (flush)                    state_next = ST_IDLE;
        else if (cnt == CNT_W'(2))    state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        load_mul   = !flush;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Iteration counter and latched destination for the multiply in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      mul_addr <= '0;
      mul_we   <= 1'b0;
    end else if (mul_start) begin
      cnt      <= CNT_W'(DATA_W);
      mul_addr <= w_addr_i;
      mul_we   <= we_i;
    end else if (state == ST_BUSY) begin
      cnt      <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      we_o      <= 1'b0;
      w_addr_o  <= '0;
      w_data_o  <= '0;
    end else begin
      out_valid <= load_single || load_mul;
      if (load_single) begin
        we_o     <= we_i;
        w_addr_o <= w_addr_i;
        w_data_o <= alu_result;
      end else if (load_mul) begin
        we_o     <= mul_we;
        w_addr_o <= mul_addr;
        w_data_o <= mul_product[DATA_W-1:0];
      end
    end
  end

`ifdef EX_HILO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (load_mul) begin
      hi <= mul_product[2*DATA_W-1:DATA_W];
      lo <= mul_product[DATA_W-1:0];
    end
  end
`endif

  ex_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (reg1),
    .b       (reg2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Counter and multiplier must stay in lockstep with the FSM
  a_cnt_live: assert property (@(posedge clk) disable iff (rst)
    (state == ST_BUSY) |-> (cnt != '0 && mul_busy));
  a_done_align: assert property (@(posedge clk) disable iff (rst)
    (state == ST_DONE) |-> mul_done);

endmodule

// File: tb/tb_ex_stage_mc.sv
// Randomized bench for ex_stage_mc against a cycle-count/scoreboard reference model.
module tb_ex_stage_mc;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, we_i;
  logic [7:0]   aluop;
  logic [2:0]   alusel;
  logic [W-1:0] reg1, reg2;
  logic [4:0]   w_addr_i;
  logic         stall_req, out_valid, we_o;
  logic [4:0]   w_addr_o;
  logic [W-1:0] w_data_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          due;
    bit          is_mul;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] value;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   mul_t   = -1;
  int   zero_at = -1;
`ifdef EX_HILO_EN
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;
`endif

  always #5 clk = ~clk;

  ex_stage_mc dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .aluop     (aluop),
    .alusel    (alusel),
    .reg1      (reg1),
    .reg2      (reg2),
    .w_addr_i  (w_addr_i),
    .we_i      (we_i),
    .stall_req (stall_req),
    .out_valid (out_valid),
    .we_o      (we_o),
    .w_addr_o  (w_addr_o),
    .w_data_o  (w_data_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] sel, input logic [7:0] op,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned sh;
    logic [W-1:0] r;
    sh = a % W;
    r  = '0;
    if (sel == 3'b001) begin
      if (op == 8'h25) r = a | b;
      if (op == 8'h24) r = a & b;
      if (op == 8'h26) r = a ^ b;
      if (op == 8'h27) r = ~(a | b);
    end else if (sel == 3'b010) begin
      if (op == 8'h7C) r = b << sh;
      if (op == 8'h02) r = b >> sh;
      if (op == 8'h03) r = b[W-1] ? ~((~b) >> sh) : (b >> sh);
    end else if (sel == 3'b100) begin
      if (op == 8'h21) r = a + b;
      if (op == 8'h23) r = a - b;
    end
`ifdef EX_HILO_EN
    else if (sel == 3'b011) begin
      if (op == 8'h10) r = hi_m;
      if (op == 8'h12) r = lo_m;
    end
`endif
    return r;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check stall, advance model
  task automatic cyc_drive(input bit v, input logic [7:0] op, input logic [2:0] sel,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] addr, input bit we, input bit fl, input bit r);
    bit idle, mul_op, exp_stall;
    exp_t e;
    if (zero_at == cyc) begin
      check("rst_we", we_o, 0);
      check("rst_addr", w_addr_o, 0);
      check("rst_data", w_data_o, 0);
    end
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("out_valid", out_valid, 1);
      check("we_o", we_o, e.we);
      check("w_addr_o", w_addr_o, e.addr);
      check("w_data_o", w_data_o, e.value[W-1:0]);
`ifdef EX_HILO_EN
      if (e.is_mul) begin
        hi_m = e.value[63:32];
        lo_m = e.value[31:0];
      end
`endif
    end else begin
      check("no_valid", out_valid, 0);
    end

    rst = r; flush = fl; in_valid = v; aluop = op; alusel = sel;
    reg1 = a; reg2 = b; w_addr_i = addr; we_i = we;
    #1;
    idle      = (mul_t < 0) || (cyc > mul_t + int'(W));
    mul_op    = (sel == 3'b101) && (op == 8'hA9);
    exp_stall = (!idle && cyc <= mul_t + int'(W) - 1) || (idle && v && !fl && mul_op);
    if (!r) check("stall_req", stall_req, exp_stall);

    if (r) begin
      q.delete();
      mul_t   = -1;
      zero_at = cyc + 1;
`ifdef EX_HILO_EN
      hi_m = '0;
      lo_m = '0;
`endif
    end else if (!idle) begin
      if (fl) begin
        if (q.size() != 0 && q[$].is_mul) void'(q.pop_back());
        mul_t = -1;
      end
    end else begin
      mul_t = -1;
      if (v && !fl) begin
        e.we = we; e.addr = addr; e.is_mul = mul_op;
        if (mul_op) begin
          mul_t   = cyc;
          e.due   = cyc + int'(W) + 1;
          e.value = {32'b0, a} * {32'b0, b};
        end else begin
          e.due   = cyc + 1;
          e.value = {32'b0, ref_alu(sel, op, a, b)};
        end
        q.push_back(e);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cyc_drive(1'b0, 8'h00, 3'b000, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Present one instruction; a MUL is held through its stall and DONE cycles
  task automatic issue(input logic [7:0] op, input logic [2:0] sel, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] addr, input bit we,
                       input int flush_pct);
    bit fl;
    fl = ($urandom_range(99) < flush_pct);
    cyc_drive(1'b1, op, sel, a, b, addr, we, fl, 1'b0);
    if (!fl && sel == 3'b101 && op == 8'hA9) begin
      for (int i = 1; i <= int'(W); i++) begin
        fl = ($urandom_range(99) < flush_pct);
        cyc_drive(1'b1, op, sel, a, b, addr, we, fl, 1'b0);
        if (fl) break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lops [4] = '{8'h25, 8'h24, 8'h26, 8'h27};
    logic [7:0] sops [3] = '{8'h7C, 8'h02, 8'h03};
    logic [7:0] aops [2] = '{8'h21, 8'h23};
    logic [7:0] mops [2] = '{8'h10, 8'h12};
    logic [7:0]   op;
    logic [2:0]   sel;
    logic [W-1:0] a, b;
    int kind;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; aluop = '0; alusel = '0;
    reg1 = '0; reg2 = '0; w_addr_i = '0; we_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_we", we_o, 0);
    check("reset_addr", w_addr_o, 0);
    check("reset_data", w_data_o, 0);
    check("reset_stall", stall_req, 0);
    rst = 1'b0;

    issue(8'h25, 3'b001, 32'h0F0F_0000, 32'h0000_F0F0, 5'd5, 1'b1, 0);
    check("or_example", w_data_o, 32'h0F0F_F0F0);
    issue(8'h03, 3'b010, 32'd4, 32'h8000_0000, 5'd6, 1'b1, 0);
    check("sra_example", w_data_o, 32'hF800_0000);
    issue(8'h23, 3'b100, 32'd0, 32'd1, 5'd7, 1'b1, 0);
    check("subu_wrap", w_data_o, 32'hFFFF_FFFF);

    issue(8'hA9, 3'b101, 32'd7, 32'd6, 5'd9, 1'b1, 0);
    check("mul_7x6", w_data_o, 32'd42);
    issue(8'h25, 3'b001, 32'h1, 32'h2, 5'd10, 1'b1, 0);
    check("or_after_mul", w_data_o, 32'h3);

    for (int i = 0; i <= 9; i++)
      cyc_drive(1'b1, 8'hA9, 3'b101, 32'd3, 32'd5, 5'd11, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b1, 8'hA9, 3'b101, 32'd3, 32'd5, 5'd11, 1'b1, 1'b1, 1'b0);
    idle_cycle();
    issue(8'h25, 3'b001, 32'hA0, 32'h0B, 5'd12, 1'b1, 0);

    for (int i = 0; i <= 5; i++)
      cyc_drive(1'b1, 8'hA9, 3'b101, 32'd9, 32'd9, 5'd13, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b0, 8'h00, 3'b000, '0, '0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    idle_cycle();

    issue(8'hFF, 3'b001, 32'h1234, 32'h5678, 5'd14, 1'b1, 0);
    check("unknown_op", w_data_o, 32'd0);
    issue(8'h25, 3'b010, 32'hFFFF, 32'hFFFF, 5'd15, 1'b0, 0);
    issue(8'h10, 3'b011, 32'h1, 32'h1, 5'd16, 1'b1, 0);
    issue(8'hA9, 3'b101, 32'hFFFF_FFFF, 32'd2, 5'd17, 1'b1, 0);
    issue(8'h10, 3'b011, 32'h0, 32'h0, 5'd18, 1'b1, 0);
    issue(8'h12, 3'b011, 32'h0, 32'h0, 5'd19, 1'b1, 0);

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(9);
      a = $urandom; b = $urandom;
      if ($urandom_range(3) == 0) a = $urandom_range(40);
      if (kind <= 2) begin
        sel = 3'b001; op = lops[$urandom_range(3)];
      end else if (kind <= 4) begin
        sel = 3'b010; op = sops[$urandom_range(2)];
      end else if (kind <= 6) begin
        sel = 3'b100; op = aops[$urandom_range(1)];
      end else if (kind == 7) begin
        sel = 3'b101; op = 8'hA9;
      end else if (kind == 8) begin
        sel = 3'b011; op = mops[$urandom_range(1)];
      end else begin
        sel = 3'($urandom); op = 8'($urandom);
      end
      issue(op, sel, a, b, 5'($urandom), 1'($urandom), 3);
      if ($urandom_range(3) == 0)
        cyc_drive(1'b0, 8'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom),
                  1'($urandom), ($urandom_range(9) == 0), 1'b0);
    end

    for (int i = 0; i < int'(W) + 3; i++) idle_cycle();
    check("drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
